// File: rtl/fib_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fib_uart_pkg : shared types, ASCII constants and helpers for fib_uart_tx  |
// | Optional feature macro: FIB_UART_PARITY_EN (even parity, 8E1 frames)      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fib_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIB_UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef FIB_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    else                return 8'h37 + {4'h0, nibble};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_byte_tx : serialises one byte per load; owns baud counter, bit index |
// | Optional feature macro: FIB_UART_PARITY_EN (even parity before stop bit)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_byte_tx import fib_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_bit_end,
  output logic [3:0] o_bit_idx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] r_baud;
  logic [3:0]    r_bit_idx;
  logic [7:0]    r_data;
  logic          r_active;
  logic          r_tx;

  logic          w_bit_end;
  logic          w_frame_end;
  logic [3:0]    w_next_idx;

  assign w_bit_end   = r_active && (r_baud == CW'(CLKS_PER_BIT - 1));
  assign w_frame_end = w_bit_end && (r_bit_idx == 4'(FRAME_BITS - 1));
  assign w_next_idx  = r_bit_idx + 4'd1;

  // Line level for frame bit idx: start, data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data);
    logic [7:0] sh;
    sh = data >> (idx - 4'd1);
    if (idx == 4'd0)       return 1'b0;
    else if (idx <= 4'd8)  return sh[0];
`ifdef FIB_UART_PARITY_EN
    else if (idx == 4'd9)  return ^data;
`endif
    else                   return 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_active  <= 1'b0;
      r_tx      <= 1'b1;
    end else if (i_load) begin
      r_active  <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_data    <= i_data;
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (w_frame_end) begin
          r_active  <= 1'b0;
          r_bit_idx <= '0;
          r_tx      <= 1'b1;
        end else begin
          r_bit_idx <= w_next_idx;
          r_tx      <= frame_bit(w_next_idx, r_data);
        end
      end else begin
        r_baud <= r_baud + CW'(1);
      end
    end
  end

  assign o_tx      = r_tx;
  assign o_bit_end = w_bit_end;
  assign o_bit_idx = r_bit_idx;

endmodule
`default_nettype wire

// File: rtl/fib_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fib_uart_tx : prints each accepted sample as upper-case hex + CR LF       |
// | Optional feature macro: FIB_UART_PARITY_EN (adds PARITY state, 11-bit)    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fib_uart_tx import fib_uart_pkg::*; #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] value,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy
);

  localparam int NCHARS = WIDTH / 4;
  localparam int MSG    = NCHARS + 2;
  localparam int CIW    = $clog2(MSG);

  state_t           r_state;
  logic [CIW-1:0]   r_char_idx;
  logic [WIDTH-1:0] r_shadow;
  logic             r_ready;

  logic             w_tx;
  logic             w_bit_end;
  logic [3:0]       w_bit_idx;
  logic             w_accept;
  logic             w_last_char;
  logic             w_chain;
  logic             w_load;
  logic [7:0]       w_load_data;

  function automatic logic [7:0] msg_char(input logic [WIDTH-1:0] src,
                                          input logic [CIW-1:0]   idx);
    logic [WIDTH-1:0] sh;
    sh = src >> (4 * (NCHARS - 1 - int'(idx)));
    if (int'(idx) < NCHARS)       return hex_ascii(sh[3:0]);
    else if (int'(idx) == NCHARS) return ASCII_CR;
    else                          return ASCII_LF;
  endfunction

  assign w_accept    = valid && r_ready;
  assign w_last_char = (r_char_idx == CIW'(MSG - 1));
  assign w_chain     = (r_state == STOP) && w_bit_end && !w_last_char;
  assign w_load      = w_accept || w_chain;
  // Character 0 comes straight from the bus because the shadow loads on the same edge.
  assign w_load_data = w_accept ? msg_char(value, '0)
                                : msg_char(r_shadow, r_char_idx + CIW'(1));

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_data    (w_load_data),
    .o_tx      (w_tx),
    .o_bit_end (w_bit_end),
    .o_bit_idx (w_bit_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_char_idx <= '0;
      r_shadow   <= '0;
      r_ready    <= 1'b1;
    end else if (w_accept) begin
      r_state    <= START;
      r_char_idx <= '0;
      r_shadow   <= value;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        START: if (w_bit_end) r_state <= DATA;
`ifdef FIB_UART_PARITY_EN
        DATA:   if (w_bit_end && w_bit_idx == 4'd8) r_state <= PARITY;
        PARITY: if (w_bit_end) r_state <= STOP;
`else
        DATA:   if (w_bit_end && w_bit_idx == 4'd8) r_state <= STOP;
`endif
        STOP: begin
          if (w_bit_end) begin
            if (w_last_char) begin
              r_state    <= DONE;
              r_char_idx <= '0;
              r_ready    <= 1'b1;
            end else begin
              r_state    <= START;
              r_char_idx <= r_char_idx + CIW'(1);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = ~r_ready;
  assign tx    = w_tx;

endmodule
`default_nettype wire
